// File: rtl/inst_fetch_if.sv
// Fetch-to-instruction-memory read port: address and enable out, word back combinationally.
interface inst_fetch_if #(
  parameter int unsigned PC_WIDTH    = 6,
  parameter int unsigned INSTR_WIDTH = 16
);
  logic [PC_WIDTH-1:0]    pc;
  logic                   enable;
  logic [INSTR_WIDTH-1:0] instruction;

  modport master (output pc, enable, input instruction);
  modport slave  (input pc, enable, output instruction);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: drives instmem reads, latches words into IR for decode,
// and steps the PC with stall, branch redirect and HALT handling.
module inst_fetch #(
  parameter int unsigned PC_WIDTH    = 6,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  inst_fetch_if.master           mem,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [PC_WIDTH-1:0]    ir_pc,
  output logic                   ir_valid,
  output logic                   halted,
  output logic                   wrapped
);

  localparam int unsigned OPC_WIDTH = 4;
  localparam logic [PC_WIDTH-1:0] PC_MAX = {PC_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    pc_r;
  logic                   enable_r;
  logic [PC_WIDTH-1:0]    pc_next;
  logic [OPC_WIDTH-1:0]   opcode;
  logic                   pc_at_max;

  assign mem.pc     = pc_r;
  assign mem.enable = enable_r;
  assign pc_next    = pc_r + PC_WIDTH'(1);
  assign opcode     = mem.instruction[INSTR_WIDTH-1 -: OPC_WIDTH];
  assign pc_at_max  = (pc_r == PC_MAX);

  // enable is registered alongside state so it is high exactly while in FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc_r     <= '0;
      enable_r <= 1'b0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
      wrapped  <= 1'b0;
    end else begin
      wrapped <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            enable_r <= 1'b1;
          end
        end
        FETCH: begin
          if (branch_taken) begin
            pc_r     <= branch_target;
            ir       <= '0;
            ir_valid <= 1'b0;
          end else if (!stall) begin
            ir       <= mem.instruction;
            ir_pc    <= pc_r;
            ir_valid <= 1'b1;
            if (opcode == HALT_OPCODE) begin
              state    <= HALT;
              enable_r <= 1'b0;
              halted   <= 1'b1;
            end else begin
              pc_r    <= pc_next;
              wrapped <= pc_at_max;
            end
          end
        end
        HALT: begin
          // The HALT word itself is valid for one cycle only; resume steps past it.
          ir_valid <= 1'b0;
          if (start) begin
            pc_r     <= pc_next;
            wrapped  <= pc_at_max;
            halted   <= 1'b0;
            state    <= FETCH;
            enable_r <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          enable_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
